// File: rtl/tag_ram_ctrl_if.sv
// Cache-side and tag-RAM-side signal bundle for tag_ram_ctrl.
// The slave modport is the controller; the master modport is the cache pipeline plus the RAM.
interface tag_ram_ctrl_if #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 20
);
    logic                lookup_valid_i;
    logic [31:0]         lookup_addr_i;
    logic                lookup_ready_o;
    logic                hit_valid_o;
    logic                hit_o;
    logic                hit_dirty_o;
    logic [TAG_W-1:0]    hit_tag_o;
    logic                upd_valid_i;
    logic [IDX_W-1:0]    upd_idx_i;
    logic [TAG_W+1:0]    upd_data_i;
    logic                upd_ready_o;
    logic                inv_all_i;
    logic                busy_o;
    logic                ram_cen_o;
    logic                ram_wen_o;
    logic [IDX_W-1:0]    ram_a_o;
    logic [TAG_W+1:0]    ram_d_o;
    logic [TAG_W+1:0]    ram_q_i;

    modport slave (
        input  lookup_valid_i, lookup_addr_i, upd_valid_i, upd_idx_i, upd_data_i,
               inv_all_i, ram_q_i,
        output lookup_ready_o, hit_valid_o, hit_o, hit_dirty_o, hit_tag_o,
               upd_ready_o, busy_o, ram_cen_o, ram_wen_o, ram_a_o, ram_d_o
    );

    modport master (
        output lookup_valid_i, lookup_addr_i, upd_valid_i, upd_idx_i, upd_data_i,
               inv_all_i, ram_q_i,
        input  lookup_ready_o, hit_valid_o, hit_o, hit_dirty_o, hit_tag_o,
               upd_ready_o, busy_o, ram_cen_o, ram_wen_o, ram_a_o, ram_d_o
    );
endinterface

// File: rtl/tag_ram_ctrl.sv
// Tag RAM front end: arbitrates updates over lookups, compares the returned tag one
// cycle later, and clears every entry with a full sweep after reset or on request.
module tag_ram_ctrl #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 20,
    parameter int OFS_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    tag_ram_ctrl_if.slave bus
);
    localparam int               WORD_W   = TAG_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_sweep_cnt;
    logic               r_vld_p1;
    logic [TAG_W-1:0]   r_req_tag_p1;

    logic               w_run;
    logic               w_sweep_wr;
    logic               w_inv;
    logic               w_upd_rdy;
    logic               w_lkp_rdy;
    logic               w_upd_acc;
    logic               w_lkp_acc;
    logic [TAG_W-1:0]   w_lkp_tag;
    logic [IDX_W-1:0]   w_lkp_idx;
    logic               w_unused_ofs;

    function automatic logic tag_hit(input logic [WORD_W-1:0] word,
                                     input logic [TAG_W-1:0]  tag);
        return word[WORD_W-1] && (word[TAG_W-1:0] == tag);
    endfunction

    assign w_lkp_tag    = bus.lookup_addr_i[OFS_W+IDX_W +: TAG_W];
    assign w_lkp_idx    = bus.lookup_addr_i[OFS_W +: IDX_W];
    assign w_unused_ofs = ^bus.lookup_addr_i[OFS_W-1:0];

    // Priority: invalidate request, then update, then lookup; all gated off while rst is high.
    assign w_run      = !rst && (r_state == RUN);
    assign w_sweep_wr = !rst && (r_state == SWEEP);
    assign w_inv      = w_run && bus.inv_all_i;
    assign w_upd_rdy  = w_run && !bus.inv_all_i;
    assign w_lkp_rdy  = w_upd_rdy && !bus.upd_valid_i;
    assign w_upd_acc  = w_upd_rdy && bus.upd_valid_i;
    assign w_lkp_acc  = w_lkp_rdy && bus.lookup_valid_i;

    assign bus.upd_ready_o    = w_upd_rdy;
    assign bus.lookup_ready_o = w_lkp_rdy;
    assign bus.busy_o         = rst || (r_state == SWEEP);

    always_comb begin
        bus.ram_cen_o = 1'b0;
        bus.ram_wen_o = 1'b0;
        bus.ram_a_o   = '0;
        bus.ram_d_o   = '0;
        if (w_sweep_wr) begin
            bus.ram_cen_o = 1'b1;
            bus.ram_wen_o = 1'b1;
            bus.ram_a_o   = r_sweep_cnt;
        end else if (w_upd_acc) begin
            bus.ram_cen_o = 1'b1;
            bus.ram_wen_o = 1'b1;
            bus.ram_a_o   = bus.upd_idx_i;
            bus.ram_d_o   = bus.upd_data_i;
        end else if (w_lkp_acc) begin
            bus.ram_cen_o = 1'b1;
            bus.ram_a_o   = w_lkp_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SWEEP;
            r_sweep_cnt <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_vld_p1 <= w_lkp_acc;
            case (r_state)
                SWEEP: begin
                    r_sweep_cnt <= r_sweep_cnt + ONE_IDX;
                    if (r_sweep_cnt == LAST_IDX) r_state <= RUN;
                end
                RUN: begin
                    if (w_inv) begin
                        r_state     <= SWEEP;
                        r_sweep_cnt <= '0;
                    end
                end
                default: r_state <= SWEEP;
            endcase
        end
    end

    // Stage p1: RAM word returns; compare against the tag captured at accept.
    always_ff @(posedge clk) begin
        if (w_lkp_acc) r_req_tag_p1 <= w_lkp_tag;
    end

    assign bus.hit_valid_o = r_vld_p1;
    assign bus.hit_o       = r_vld_p1 && tag_hit(bus.ram_q_i, r_req_tag_p1);
    assign bus.hit_dirty_o = r_vld_p1 && bus.ram_q_i[TAG_W];
    assign bus.hit_tag_o   = bus.ram_q_i[TAG_W-1:0];
endmodule
